// File: rtl/md5_multi_ctx_cruncher.sv
// MD5 compression engine: one step per clock over NUM_CTX independent chaining values.
// Optional abort input when MD5_ABORT_EN is defined.
//
// state    | meaning
// S_IDLE   | waiting for start
// S_CRUNCH | running MD5 step i (0..63), one per cycle
// S_FINAL  | folding working regs into CV[act]
// S_DONE   | done pulse; a new start is accepted here too
module md5_multi_ctx_cruncher #(
  parameter int NUM_CTX = 2,
  parameter int CTX_W   = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               init,
  input  logic [CTX_W-1:0]   ctx_sel,
  output logic               busy,
  output logic               done,
  output logic [CTX_W-1:0]   done_ctx,
  output logic [5:0]         iaddr,
  input  logic [31:0]        kdata,
  input  logic [4:0]         sdata,
  output logic [CTX_W-1:0]   msg_ctx,
  output logic [3:0]         gaddr,
  input  logic [31:0]        mdata,
  input  logic [CTX_W-1:0]   rd_ctx,
  output logic [127:0]       digest
`ifdef MD5_ABORT_EN
  ,
  input  logic               abort
`endif
);

  localparam logic [127:0] IV = {32'h10325476, 32'h98badcfe, 32'hefcdab89, 32'h67452301};

  typedef enum logic [1:0] {S_IDLE, S_CRUNCH, S_FINAL, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [CTX_W-1:0] act;
  logic [5:0]       step;
  logic [31:0]      a, b, c, d;
  logic [127:0]     cv [NUM_CTX];

  logic             abort_hit;
  logic             sel_ok;
  logic             accept;
  logic [127:0]     cv_sel, cv_act, cv_rd;
  logic [31:0]      f, sum, rot, step_b;
  logic [3:0]       g;

`ifdef MD5_ABORT_EN
  assign abort_hit = abort && ((state == S_CRUNCH) || (state == S_FINAL));
`else
  assign abort_hit = 1'b0;
`endif

  // Context muxes by compare so out-of-range indices read as zero / invalid.
  always_comb begin
    sel_ok = 1'b0;
    cv_sel = '0;
    cv_act = '0;
    cv_rd  = '0;
    for (int n = 0; n < NUM_CTX; n++) begin
      if (ctx_sel == CTX_W'(n)) begin
        sel_ok = 1'b1;
        cv_sel = cv[n];
      end
      if (act == CTX_W'(n)) cv_act = cv[n];
      if (rd_ctx == CTX_W'(n)) cv_rd = cv[n];
    end
  end

  assign accept = start && sel_ok && ((state == S_IDLE) || (state == S_DONE));

  always_comb begin
    f = '0;
    g = step[3:0];
    case (step[5:4])
      2'd0: begin
        f = (b & c) | (~b & d);
        g = step[3:0];
      end
      2'd1: begin
        f = (d & b) | (~d & c);
        g = step[3:0] * 4'd5 + 4'd1;
      end
      2'd2: begin
        f = b ^ c ^ d;
        g = step[3:0] * 4'd3 + 4'd5;
      end
      default: begin
        f = c ^ (b | ~d);
        g = step[3:0] * 4'd7;
      end
    endcase
    sum    = a + f + kdata + mdata;
    // A right shift by 32 yields zero, so sdata=0 degenerates to identity.
    rot    = (sum << sdata) | (sum >> (6'd32 - {1'b0, sdata}));
    step_b = b + rot;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: state_nxt = accept ? S_CRUNCH : S_IDLE;
      S_CRUNCH:       if (step == 6'd63) state_nxt = S_FINAL;
      S_FINAL:        state_nxt = S_DONE;
      default:        state_nxt = S_IDLE;
    endcase
    if (abort_hit) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      act   <= '0;
      step  <= '0;
      a     <= '0;
      b     <= '0;
      c     <= '0;
      d     <= '0;
      for (int n = 0; n < NUM_CTX; n++) cv[n] <= IV;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            act  <= ctx_sel;
            step <= '0;
            if (init) {d, c, b, a} <= IV;
            else      {d, c, b, a} <= cv_sel;
          end
        end
        S_CRUNCH: begin
          if (abort_hit) begin
            step <= '0;
          end else begin
            a    <= d;
            b    <= step_b;
            c    <= b;
            d    <= c;
            step <= step + 6'd1;
          end
        end
        default: ;
      endcase
      // CV[act] keeps the pre-chunk value until FINAL, so it doubles as the feed-forward operand.
      for (int n = 0; n < NUM_CTX; n++) begin
        if (accept && init && (ctx_sel == CTX_W'(n)))
          cv[n] <= IV;
        else if ((state == S_FINAL) && !abort_hit && (act == CTX_W'(n)))
          cv[n] <= {cv_act[127:96] + d, cv_act[95:64] + c, cv_act[63:32] + b, cv_act[31:0] + a};
      end
    end
  end

  assign busy     = (state == S_CRUNCH) || (state == S_FINAL);
  assign done     = (state == S_DONE);
  assign done_ctx = done ? act : '0;
  assign iaddr    = step;
  assign gaddr    = g;
  assign msg_ctx  = busy ? act : ctx_sel;
  assign digest   = cv_rd;

endmodule

// File: tb/tb_md5_multi_ctx_cruncher.sv
// Directed bench for md5_multi_ctx_cruncher with three contexts (ctx 3 is out of range).
// Abort scenario runs only when MD5_ABORT_EN is defined.
module tb_md5_multi_ctx_cruncher;
  localparam int NCTX = 3;
  localparam int CW   = 2;

  localparam logic [127:0] IV       = 128'h10325476_98badcfe_efcdab89_67452301;
  localparam logic [127:0] DG_EMPTY = 128'h7e42f8ec_980980e9_04b2008f_d98c1dd4;
  localparam logic [127:0] DG_ABC   = 128'h727fe128_7d3f96d6_b04fd23c_98500190;

  localparam logic [31:0] KTAB [64] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
    32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
    32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
    32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
    32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
    32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
    32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
    32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
    32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };
  localparam int STAB [16] = '{7, 12, 17, 22, 5, 9, 14, 20, 4, 11, 16, 23, 6, 10, 15, 21};

  logic          clk = 1'b0;
  logic          reset, start, init;
  logic [CW-1:0] ctx_sel, rd_ctx, msg_ctx, done_ctx;
  logic          busy, done;
  logic [5:0]    iaddr;
  logic [3:0]    gaddr;
  logic [31:0]   kdata, mdata;
  logic [4:0]    sdata;
  logic [127:0]  digest;
`ifdef MD5_ABORT_EN
  logic          abort = 1'b0;
`endif

  logic [31:0] mbuf [4][16];
  int checks = 0;
  int errors = 0;

  md5_multi_ctx_cruncher #(.NUM_CTX(NCTX), .CTX_W(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .init(init), .ctx_sel(ctx_sel),
    .busy(busy), .done(done), .done_ctx(done_ctx), .iaddr(iaddr), .kdata(kdata),
    .sdata(sdata), .msg_ctx(msg_ctx), .gaddr(gaddr), .mdata(mdata),
    .rd_ctx(rd_ctx), .digest(digest)
`ifdef MD5_ABORT_EN
    , .abort(abort)
`endif
  );

  always #5 clk = ~clk;

  assign kdata = KTAB[iaddr];
  assign sdata = 5'(STAB[{iaddr[5:4], iaddr[1:0]}]);
  assign mdata = mbuf[msg_ctx][gaddr];

  // Reference MD5 compression of mbuf[ctx] onto a given chaining value.
  function automatic logic [127:0] md5_ref(input logic [127:0] cv, input int ctx);
    logic [31:0] a, b, c, d, f, t, r;
    int g, s;
    a = cv[31:0]; b = cv[63:32]; c = cv[95:64]; d = cv[127:96];
    for (int i = 0; i < 64; i++) begin
      if (i < 16)      begin f = (b & c) | (~b & d); g = i; end
      else if (i < 32) begin f = (d & b) | (~d & c); g = (5 * i + 1) % 16; end
      else if (i < 48) begin f = b ^ c ^ d;          g = (3 * i + 5) % 16; end
      else             begin f = c ^ (b | ~d);       g = (7 * i) % 16; end
      s = STAB[(i / 16) * 4 + (i % 4)];
      t = a + f + KTAB[i] + mbuf[ctx][g];
      r = (t << s) | (t >> (32 - s));
      a = d; d = c; c = b; b = b + r;
    end
    return {cv[127:96] + d, cv[95:64] + c, cv[63:32] + b, cv[31:0] + a};
  endfunction

  task automatic load_empty(input int c);
    for (int j = 0; j < 16; j++) mbuf[c][j] = 32'h0;
    mbuf[c][0] = 32'h00000080;
  endtask

  task automatic load_abc(input int c);
    for (int j = 0; j < 16; j++) mbuf[c][j] = 32'h0;
    mbuf[c][0]  = 32'h80636261;
    mbuf[c][14] = 32'h00000018;
  endtask

  // Holds start for the acceptance cycle; returns at the negedge of T+1.
  task automatic start_chunk(input logic [CW-1:0] c, input logic in);
    @(negedge clk);
    start = 1'b1; init = in; ctx_sel = c;
    @(negedge clk);
    start = 1'b0; init = 1'b0;
  endtask

  task automatic wait_done(output int k);
    k = 1;
    while (done !== 1'b1 && k < 150) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; init = 1'b0; ctx_sel = 2'd2; rd_ctx = 2'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (done_ctx !== 2'd0) begin errors++; $display("FAIL reset_done_ctx: got %0d want 0", done_ctx); end
    checks++; if (iaddr !== 6'd0) begin errors++; $display("FAIL reset_iaddr: got %0d want 0", iaddr); end
    checks++; if (gaddr !== 4'd0) begin errors++; $display("FAIL reset_gaddr: got %0d want 0", gaddr); end
    checks++; if (msg_ctx !== 2'd2) begin errors++; $display("FAIL reset_msg_ctx: got %0d want 2", msg_ctx); end
    ctx_sel = 2'd1; #1;
    checks++; if (msg_ctx !== 2'd1) begin errors++; $display("FAIL idle_msg_ctx: got %0d want 1", msg_ctx); end
    for (int n = 0; n < NCTX; n++) begin
      rd_ctx = CW'(n); #1;
      checks++; if (digest !== IV) begin errors++; $display("FAIL reset_digest%0d: got %h want %h", n, digest, IV); end
    end
    rd_ctx = 2'd3; #1;
    checks++; if (digest !== 128'h0) begin errors++; $display("FAIL rd_invalid: got %h want 0", digest); end
  endtask

  task automatic test_abc;
    int k;
    load_abc(1);
    rd_ctx = 2'd1;
    start_chunk(2'd1, 1'b1);
    wait_done(k);
    checks++; if (k != 66) begin errors++; $display("FAIL abc_latency: got %0d want 66", k); end
    checks++; if (done_ctx !== 2'd1) begin errors++; $display("FAIL abc_done_ctx: got %0d want 1", done_ctx); end
    checks++; if (digest !== DG_ABC) begin errors++; $display("FAIL abc_digest: got %h want %h", digest, DG_ABC); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL abc_done_pulse: got %b want 0", done); end
    rd_ctx = 2'd0; #1;
    checks++; if (digest !== IV) begin errors++; $display("FAIL abc_ctx0_iv: got %h want %h", digest, IV); end
  endtask

  task automatic test_empty;
    int k;
    load_empty(0);
    rd_ctx = 2'd0;
    start_chunk(2'd0, 1'b1);
    k = 1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL empty_busy: got %b want 1", busy); end
    checks++; if (iaddr !== 6'd0) begin errors++; $display("FAIL empty_iaddr0: got %0d want 0", iaddr); end
    while (done !== 1'b1 && k < 150) begin
      @(negedge clk);
      k++;
      if (k == 10) begin
        checks++; if (digest !== IV) begin errors++; $display("FAIL empty_mid_digest: got %h want %h", digest, IV); end
      end
      if (k == 18) begin
        checks++; if (iaddr !== 6'd17 || gaddr !== 4'd6) begin errors++; $display("FAIL step17_addr: got i=%0d g=%0d want 17/6", iaddr, gaddr); end
      end
      if (k == 35) begin
        checks++; if (iaddr !== 6'd34 || gaddr !== 4'd11) begin errors++; $display("FAIL step34_addr: got i=%0d g=%0d want 34/11", iaddr, gaddr); end
      end
      if (k == 52) begin
        checks++; if (iaddr !== 6'd51 || gaddr !== 4'd5) begin errors++; $display("FAIL step51_addr: got i=%0d g=%0d want 51/5", iaddr, gaddr); end
      end
      if (k == 65) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL final_busy: got %b want 1", busy); end
      end
    end
    checks++; if (k != 66) begin errors++; $display("FAIL empty_latency: got %0d want 66", k); end
    checks++; if (done_ctx !== 2'd0) begin errors++; $display("FAIL empty_done_ctx: got %0d want 0", done_ctx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL done_busy: got %b want 0", busy); end
    checks++; if (digest !== DG_EMPTY) begin errors++; $display("FAIL empty_digest: got %h want %h", digest, DG_EMPTY); end
    rd_ctx = 2'd1; #1;
    checks++; if (digest !== DG_ABC) begin errors++; $display("FAIL empty_ctx1_kept: got %h want %h", digest, DG_ABC); end
  endtask

  task automatic test_continue;
    int k;
    logic [127:0] exp;
    load_abc(0);
    exp = md5_ref(DG_EMPTY, 0);
    rd_ctx = 2'd0;
    start_chunk(2'd0, 1'b0);
    @(negedge clk);
    checks++; if (digest !== DG_EMPTY) begin errors++; $display("FAIL cont_mid_digest: got %h want %h", digest, DG_EMPTY); end
    wait_done(k);
    checks++; if (k != 65) begin errors++; $display("FAIL cont_latency: got %0d want 65 after extra wait", k); end
    checks++; if (digest !== exp) begin errors++; $display("FAIL cont_digest: got %h want %h", digest, exp); end
  endtask

  task automatic test_back_to_back;
    int k1, k2;
    load_empty(0);
    load_abc(1);
    start_chunk(2'd0, 1'b1);
    wait_done(k1);
    checks++; if (k1 != 66 || done_ctx !== 2'd0) begin errors++; $display("FAIL b2b_first: got k=%0d ctx=%0d want 66/0", k1, done_ctx); end
    start = 1'b1; init = 1'b1; ctx_sel = 2'd1; rd_ctx = 2'd0; #1;
    checks++; if (digest !== DG_EMPTY) begin errors++; $display("FAIL b2b_digest0: got %h want %h", digest, DG_EMPTY); end
    @(negedge clk);
    start = 1'b0; init = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: got busy=%b want 1", busy); end
    wait_done(k2);
    checks++; if (k2 != 66 || done_ctx !== 2'd1) begin errors++; $display("FAIL b2b_second: got k=%0d ctx=%0d want 66/1", k2, done_ctx); end
    rd_ctx = 2'd1; #1;
    checks++; if (digest !== DG_ABC) begin errors++; $display("FAIL b2b_digest1: got %h want %h", digest, DG_ABC); end
    rd_ctx = 2'd0; #1;
    checks++; if (digest !== DG_EMPTY) begin errors++; $display("FAIL b2b_digest0_kept: got %h want %h", digest, DG_EMPTY); end
  endtask

  task automatic test_start_ignored;
    int k;
    load_empty(0);
    start_chunk(2'd0, 1'b1);
    k = 1;
    while (done !== 1'b1 && k < 150) begin
      @(negedge clk);
      k++;
      if (k == 10) begin
        start = 1'b1; init = 1'b1; ctx_sel = 2'd1; #1;
        checks++; if (msg_ctx !== 2'd0) begin errors++; $display("FAIL busy_msg_ctx: got %0d want 0", msg_ctx); end
      end else if (k == 11) begin
        start = 1'b0; init = 1'b0; ctx_sel = 2'd0;
      end
    end
    checks++; if (k != 66 || done_ctx !== 2'd0) begin errors++; $display("FAIL ign_done: got k=%0d ctx=%0d want 66/0", k, done_ctx); end
    rd_ctx = 2'd0; #1;
    checks++; if (digest !== DG_EMPTY) begin errors++; $display("FAIL ign_digest0: got %h want %h", digest, DG_EMPTY); end
    rd_ctx = 2'd1; #1;
    checks++; if (digest !== DG_ABC) begin errors++; $display("FAIL ign_digest1: got %h want %h", digest, DG_ABC); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL ign_idle: got busy=%b done=%b want 0/0", busy, done); end
  endtask

  task automatic test_invalid_ctx;
    int nd;
    start_chunk(2'd3, 1'b1);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL inv_busy: got %b want 0", busy); end
    nd = 0;
    repeat (80) begin @(negedge clk); if (done === 1'b1) nd++; end
    checks++; if (nd != 0) begin errors++; $display("FAIL inv_no_done: got %0d dones want 0", nd); end
    rd_ctx = 2'd0; #1;
    checks++; if (digest !== DG_EMPTY) begin errors++; $display("FAIL inv_digest0: got %h want %h", digest, DG_EMPTY); end
    ctx_sel = 2'd0;
  endtask

  task automatic test_reset_mid;
    int k, nd;
    start_chunk(2'd1, 1'b0);
    k = 1;
    while (k < 30) begin @(negedge clk); k++; end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rst_mid: got busy=%b done=%b want 0/0", busy, done); end
    reset = 1'b0;
    nd = 0;
    repeat (80) begin @(negedge clk); if (done === 1'b1) nd++; end
    checks++; if (nd != 0) begin errors++; $display("FAIL rst_no_done: got %0d dones want 0", nd); end
    for (int n = 0; n < NCTX; n++) begin
      rd_ctx = CW'(n); #1;
      checks++; if (digest !== IV) begin errors++; $display("FAIL rst_digest%0d: got %h want %h", n, digest, IV); end
    end
  endtask

`ifdef MD5_ABORT_EN
  task automatic test_abort;
    int k, nd;
    logic [127:0] exp;
    load_empty(0);
    rd_ctx = 2'd0;
    start_chunk(2'd0, 1'b1);
    wait_done(k);
    checks++; if (digest !== DG_EMPTY) begin errors++; $display("FAIL abort_setup: got %h want %h", digest, DG_EMPTY); end
    load_abc(0);
    exp = md5_ref(DG_EMPTY, 0);
    start_chunk(2'd0, 1'b0);
    k = 1;
    while (k < 20) begin @(negedge clk); k++; end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
    nd = 0;
    repeat (80) begin @(negedge clk); if (done === 1'b1) nd++; end
    checks++; if (nd != 0) begin errors++; $display("FAIL abort_no_done: got %0d dones want 0", nd); end
    checks++; if (digest !== DG_EMPTY) begin errors++; $display("FAIL abort_cv: got %h want %h", digest, DG_EMPTY); end
    start_chunk(2'd0, 1'b0);
    wait_done(k);
    checks++; if (k != 66) begin errors++; $display("FAIL abort_resume_latency: got %0d want 66", k); end
    checks++; if (digest !== exp) begin errors++; $display("FAIL abort_resume_digest: got %h want %h", digest, exp); end
  endtask
`endif

  initial begin
    for (int c = 0; c < 4; c++) for (int j = 0; j < 16; j++) mbuf[c][j] = 32'h0;
    test_reset;
    test_abc;
    test_empty;
    test_continue;
    test_back_to_back;
    test_start_ignored;
    test_invalid_ctx;
    test_reset_mid;
`ifdef MD5_ABORT_EN
    test_abort;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
